// File: rtl/contador_pc.sv
// Program counter, index register and LIFO return stack for CALL/RET.
// One-cycle update from cs/dato/cero; no handshake, stack faults set a sticky error.
module contador_pc #(
    parameter int PILA_PROF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] cs,
    input  logic [7:0] dato,
    input  logic       cero,
    output logic [7:0] pcout,
    output logic [7:0] ix,
    output logic       pila_vacia,
    output logic       pila_llena,
    output logic       err_pila
);

    localparam int IDXW = (PILA_PROF > 1) ? $clog2(PILA_PROF) : 1;
    localparam int SPW  = IDXW + 1;

    localparam logic [4:0] OP_INC   = 5'b00001;
    localparam logic [4:0] OP_JMP   = 5'b00010;
    localparam logic [4:0] OP_JZ    = 5'b00011;
    localparam logic [4:0] OP_CALL  = 5'b00100;
    localparam logic [4:0] OP_RET   = 5'b00101;
    localparam logic [4:0] OP_LDIX  = 5'b01000;
    localparam logic [4:0] OP_INCIX = 5'b01001;
    localparam logic [4:0] OP_DECIX = 5'b01010;

    logic [7:0]     pc_q, pc_d;
    logic [7:0]     ix_q, ix_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           push_en;
    logic [IDXW-1:0] push_idx, pop_idx;
    logic [7:0]     pila_q [PILA_PROF];

    assign pila_vacia = (sp_q == '0);
    assign pila_llena = (sp_q == SPW'(PILA_PROF));
    assign push_idx   = IDXW'(sp_q);
    assign pop_idx    = IDXW'(sp_q - SPW'(1));

    always_comb begin
        pc_d    = pc_q;
        ix_d    = ix_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        case (cs)
            OP_INC:   pc_d = pc_q + 8'd1;
            OP_JMP:   pc_d = dato;
            OP_JZ:    pc_d = cero ? dato : pc_q + 8'd1;
            OP_CALL: begin
                // A faulting CALL/RET leaves pc and sp alone; only the error latches.
                if (pila_llena) begin
                    err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SPW'(1);
                    pc_d    = dato;
                end
            end
            OP_RET: begin
                if (pila_vacia) begin
                    err_d = 1'b1;
                end else begin
                    sp_d = sp_q - SPW'(1);
                    pc_d = pila_q[pop_idx];
                end
            end
            OP_LDIX:  ix_d = dato;
            OP_INCIX: ix_d = ix_q + 8'd1;
            OP_DECIX: ix_d = ix_q - 8'd1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= 8'h00;
            ix_q  <= 8'h00;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ix_q  <= ix_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage is never cleared; only sp defines what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            pila_q[push_idx] <= pc_q;
        end
    end

    assign pcout    = pc_q;
    assign ix       = ix_q;
    assign err_pila = err_q;

endmodule
